// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M execute-stage multiply/divide unit.
package muldiv_pkg;
  localparam int MULDIV_XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, DIV, DONE} muldiv_state_t;
endpackage

// File: rtl/muldiv_div_iter.sv
// Restoring divider datapath: one quotient bit per step on unsigned magnitudes.
module muldiv_div_iter import muldiv_pkg::*; #(
  parameter int XLEN      = MULDIV_XLEN,
  parameter int CNT_WIDTH = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quo_nxt_o,
  output logic [XLEN-1:0] rem_nxt_o,
  output logic            last_o
);
  logic [XLEN-1:0]      rem_q, quo_q, dvs_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [XLEN:0]        rem_sh, diff;

  // Partial remainder stays below the divisor, so XLEN+1 bits hold the shifted value.
  assign rem_sh    = {rem_q, quo_q[XLEN-1]};
  assign diff      = rem_sh - {1'b0, dvs_q};
  assign rem_nxt_o = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_nxt_o = {quo_q[XLEN-2:0], ~diff[XLEN]};
  assign last_o    = (cnt_q == CNT_WIDTH'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
      cnt_q <= CNT_WIDTH'(XLEN);
    end else if (step_i) begin
      rem_q <= rem_nxt_o;
      quo_q <= quo_nxt_o;
      cnt_q <= cnt_q - CNT_WIDTH'(1);
    end
  end
endmodule

// File: rtl/muldiv_unit_e.sv
// Execute-stage RV32M unit: single-cycle multiply, XLEN-step iterative divide.
module muldiv_unit_e import muldiv_pkg::*; #(
  parameter int XLEN      = MULDIV_XLEN,
  parameter int CNT_WIDTH = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  muldiv_state_t state_q;
  logic [2:0]    funct3_q;
  logic          q_neg_q, r_neg_q, done_q;
  logic [XLEN-1:0] result_q;

  logic accept, is_div, is_uns, a_sgn, b_sgn, div_zero, div_ovf, load;
  logic signed [XLEN:0]     mul_a, mul_b;
  logic signed [2*XLEN+1:0] prod;
  logic [XLEN-1:0] mul_res, abs_a, abs_b, quo_nxt, rem_nxt, fix_q, fix_r;
  logic            last, unused_prod;

  assign accept = (state_q == IDLE) && start_i && !flush_i;
  assign busy_o = accept || (state_q == DIV);
  assign done_o = done_q;
  assign result_o = result_q;

  assign is_div   = funct3_i[2];
  assign is_uns   = funct3_i[0];
  assign a_sgn    = !is_uns && op_a_i[XLEN-1];
  assign b_sgn    = !is_uns && op_b_i[XLEN-1];
  assign div_zero = (op_b_i == '0);
  assign div_ovf  = !is_uns && (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b_i);
  assign load     = accept && is_div && !div_zero && !div_ovf;

  // rs1 is signed for all but MULHU, rs2 only for MUL/MULH.
  assign mul_a       = {(funct3_i[1:0] != 2'b11) && op_a_i[XLEN-1], op_a_i};
  assign mul_b       = {!funct3_i[1] && op_b_i[XLEN-1], op_b_i};
  assign prod        = mul_a * mul_b;
  assign mul_res     = (funct3_i[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign unused_prod = ^prod[2*XLEN+1:2*XLEN];

  assign abs_a = a_sgn ? -op_a_i : op_a_i;
  assign abs_b = b_sgn ? -op_b_i : op_b_i;
  assign fix_q = q_neg_q ? -quo_nxt : quo_nxt;
  assign fix_r = r_neg_q ? -rem_nxt : rem_nxt;

  muldiv_div_iter #(.XLEN(XLEN), .CNT_WIDTH(CNT_WIDTH)) u_div (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (flush_i),
    .load_i     (load),
    .step_i     ((state_q == DIV) && !flush_i),
    .dividend_i (abs_a),
    .divisor_i  (abs_b),
    .quo_nxt_o  (quo_nxt),
    .rem_nxt_o  (rem_nxt),
    .last_o     (last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      funct3_q <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            funct3_q <= funct3_i;
            q_neg_q  <= a_sgn ^ b_sgn;
            r_neg_q  <= a_sgn;
            if (!is_div) begin
              result_q <= mul_res;
              state_q  <= DONE;
              done_q   <= 1'b1;
            end else if (div_zero) begin
              result_q <= funct3_i[1] ? op_a_i : '1;
              state_q  <= DONE;
              done_q   <= 1'b1;
            end else if (div_ovf) begin
              result_q <= funct3_i[1] ? '0 : op_a_i;
              state_q  <= DONE;
              done_q   <= 1'b1;
            end else begin
              state_q <= DIV;
            end
          end
        end
        DIV: if (last) begin
          result_q <= funct3_q[1] ? fix_r : fix_q;
          state_q  <= DONE;
          done_q   <= 1'b1;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit_e.sv
// Directed and random checks of muldiv_unit_e against an arithmetic reference model.
module tb_muldiv_unit_e;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] op_a_i = '0, op_b_i = '0;
  logic        busy_o, done_o;
  logic [31:0] result_o;

  int nchk = 0;
  int nfail = 0;

  muldiv_unit_e dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .flush_i(flush_i),
    .funct3_i(funct3_i), .op_a_i(op_a_i), .op_b_i(op_b_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    bit ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bit ovf;
    ovf = !f3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    return (f3[2] && b != 0 && !ovf) ? 33 : 1;
  endfunction

  // Issue one op, follow it to done_o, check latency, busy span and result.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp;
    int explat, lat, bcnt;
    exp    = ref_res(f3, a, b);
    explat = ref_lat(f3, a, b);
    lat    = 0;
    @(negedge clk_i);
    funct3_i = f3; op_a_i = a; op_b_i = b; start_i = 1'b1;
    #1 bcnt = busy_o ? 1 : 0;
    do begin
      @(negedge clk_i);
      start_i = 1'b0;
      lat++;
      if (busy_o && !done_o) bcnt++;
    end while (!done_o && lat < 60);
    chk({tag, "_lat"}, lat, explat);
    chk({tag, "_busy"}, bcnt, explat);
    chk({tag, "_res"}, result_o, exp);
    chk({tag, "_busy_at_done"}, {31'b0, busy_o}, 32'h0);
    @(negedge clk_i);
    chk({tag, "_done_pulse"}, {31'b0, done_o}, 32'h0);
  endtask

  initial begin
    int dcnt;
    logic [2:0] f3;
    logic [31:0] a, b;
    #12;
    chk("rst_busy", {31'b0, busy_o}, 32'h0);
    chk("rst_done", {31'b0, done_o}, 32'h0);
    chk("rst_result", result_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul");
    do_op(3'd3, 32'd7, 32'hFFFF_FFFD, "mulhu");
    do_op(3'd4, 32'hFFFF_FFEC, 32'd3, "div");
    do_op(3'd6, 32'hFFFF_FFEC, 32'd3, "rem");
    do_op(3'd5, 32'h8000_0000, 32'd0, "divu_zero");
    do_op(3'd7, 32'h8000_0000, 32'd0, "remu_zero");
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh");
    do_op(3'd5, 32'hFFFF_FFFF, 32'd7, "divu");

    // Flush in the middle of a divide: back to idle, no result.
    @(negedge clk_i);
    funct3_i = 3'd4; op_a_i = 32'd1000; op_b_i = 32'd7; start_i = 1'b1;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk_i);
      start_i = 1'b0;
    end
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    chk("flush_busy", {31'b0, busy_o}, 32'h0);
    dcnt = 0;
    for (int i = 0; i < 35; i++) begin
      if (done_o) dcnt++;
      @(negedge clk_i);
    end
    chk("flush_no_done", dcnt, 0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, "mulhsu");

    // Asynchronous reset mid-divide.
    @(negedge clk_i);
    funct3_i = 3'd4; op_a_i = 32'd12345; op_b_i = 32'd11; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (5) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy_o}, 32'h0);
    chk("arst_done", {31'b0, done_o}, 32'h0);
    chk("arst_result", result_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // start_i held high: DONE ignores it, so every other cycle accepts.
    funct3_i = 3'd0; op_a_i = 32'd5; op_b_i = 32'd6; start_i = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (done_o) begin
        dcnt++;
        chk("held_res", result_o, 32'd30);
      end
    end
    start_i = 1'b0;
    chk("held_done_count", dcnt, 3);

    for (int i = 0; i < 30; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 5));
        3: b = -32'($urandom_range(1, 5));
        default: ;
      endcase
      do_op(f3, a, b, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/muldiv_unit_e.md
Name: muldiv_unit_e

Overview:
- Execute-stage RV32M arithmetic unit. It consumes the operands, funct3 and M-op flag that the decode-to-execute pipeline register produces, after forwarding.
- Multiply completes in 1 cycle. Divide/remainder is iterative (XLEN cycles).
- Raises busy_o to the hazard unit while working. The hazard unit then holds F/D/E and bubbles M.
- The result is muxed into the E-stage result path when done_o is high.

Parameters:
- XLEN, 32, operand/result width.
- CNT_WIDTH, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  valid M-extension op present in E stage.
- flush_i  input  1  abort in-flight op (trap/redirect); synchronous.
- funct3_i  input  3  op select.
- op_a_i  input  XLEN  rs1 value (forwarded).
- op_b_i  input  XLEN  rs2 value (forwarded).
- busy_o  output  1  stall request to hazard unit.
- done_o  output  1  result valid, one-cycle pulse.
- result_o  output  XLEN  result, valid only when done_o=1.

Behaviour:
- funct3 encoding:
  - 000 MUL (low word)
  - 001 MULH (s×s high)
  - 010 MULHSU (s×u high)
  - 011 MULHU (u×u high)
  - 100 DIV
  - 101 DIVU
  - 110 REM
  - 111 REMU
- States: IDLE, DIV, DONE.
- Reset (async, rst_ni=0) → state=IDLE, counter=0, all internal registers 0. Outputs: busy_o=0, done_o=0, result_o=0.
- busy_o = (IDLE & start_i & ~flush_i) | (state==DIV). It is combinational so the stall applies in the accept cycle. It is low in DONE, so the pipeline advances that cycle.
- IDLE, start_i=1, flush_i=0: latch funct3, operands and signs. Then:
  - Multiply: compute the 2·XLEN product (sign-extend per op) and register the selected half. Next state DONE (latency 1).
  - Divide, op_b=0: quotient = all-ones (−1 signed, 2^XLEN−1 unsigned); remainder = op_a. Next state DONE.
  - Signed divide, op_a=−2^(XLEN−1) and op_b=−1: quotient = op_a; remainder = 0. Next state DONE.
  - Otherwise: load |a| and |b| (signed ops) or raw values, remainder accumulator=0, counter=XLEN. Next state DIV.
- DIV: one restoring step per cycle.
  - Shift {rem,quo} left 1, trial-subtract the divisor, set the quotient LSB if no borrow.
  - Counter decrements; at counter==1 the step completes and next state is DONE. Total latency from accept = XLEN+1 cycles (33).
- DONE: done_o=1 and result_o holds the final value for exactly one cycle, then IDLE.
  - Sign fix applied at DIV exit: quotient negated if sign(a)≠sign(b) for DIV; remainder takes sign(a) for REM.
  - start_i in DONE is ignored. The next op is accepted the following cycle in IDLE, by which time E holds the next instruction.
- flush_i=1 in any state → IDLE next cycle. No done_o is produced. It overrides start_i.
- Reset mid-operation: immediate return to IDLE, no result.
- result_o is don't-care-free: it holds its last value outside DONE. Bench checks it only on done_o.

Decomposition:
- Package muldiv_pkg holds:
  - funct3 localparams (F3_MUL … F3_REMU)
  - state enum muldiv_state_t {IDLE, DIV, DONE}
  - XLEN default
- One sub-module, muldiv_div_iter: the restoring-divider datapath (rem/quo/divisor registers, one-step logic, counter). The FSM, special-case detection, multiply and sign fix stay in muldiv_unit_e.

Test Plan:
- MUL a=7, b=−3 (0xFFFFFFFD), start 1 cycle → busy_o=1 in accept cycle only. Next cycle done_o=1, result=0xFFFFFFEB. MULHU same operands → 0x00000006.
- DIV a=−20, b=3 → busy_o high 33 cycles from accept; done_o on cycle 33; result=0xFFFFFFFA (−6). REM same operands → 0xFFFFFFFE (−2).
- DIVU a=0x80000000, b=0 → done next cycle, result=0xFFFFFFFF. REMU same operands → 0x80000000.
- DIV a=0x80000000, b=0xFFFFFFFF → done next cycle, result=0x80000000. REM → 0.
- DIV started, flush_i pulsed at cycle 10 → IDLE next cycle, busy_o=0, no done_o. New MULHSU a=−1, b=2 → 0xFFFFFFFF.
- rst_ni low asynchronously mid-DIV (between clock edges) → busy_o/done_o/result_o=0 immediately. After release, start_i held high through DONE → exactly one done_o per accepted op.
